module_bcd_conv_arbiter: RTL
============================

MODULE_BCD_CONV_ARBITER -- requirements
Module: module_bcd_conv_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary operand width; legal range 4..13, so that the maximum operand 8191 fits in 4 BCD digits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operand.
REQ-005 The block SHALL have port req0_bin, input, WIDTH bits: requester 0 operand.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: requester 0 operand accepted this cycle.
REQ-007 The block SHALL have ports req1_valid (input, 1), req1_bin (input, WIDTH) and req1_ready (output, 1), with the same meanings for requester 1.
REQ-008 The block SHALL have port res_valid, output, 1 bit: the result is available.
REQ-009 The block SHALL have port res_bcd, output, 16 bits: {thousands, hundreds, tens, units}, 4 bits each.
REQ-010 The block SHALL have port res_id, output, 1 bit: the requester that owns the result.
REQ-011 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-014 In IDLE the arbiter SHALL grant exactly one valid requester.
- Both valid: grant the requester holding priority (pointer).
- One valid: grant it regardless of the pointer.
REQ-015 reqN_ready SHALL be combinational: asserted only in IDLE and only for the granted requester; it is never asserted in CONV or DONE.
REQ-016 On the accept edge (reqN_valid and reqN_ready) the block SHALL:
- load the shift register with {16'b0, reqN_bin};
- load the iteration counter with WIDTH;
- latch the id;
- set the pointer to the other requester;
- go to CONV.
REQ-017 Each CONV cycle SHALL perform one double-dabble step: add 3 to every BCD nibble greater than or equal to 5, shift the whole register left by 1, and decrement the counter.
REQ-018 After exactly WIDTH CONV cycles the block SHALL go to DONE with res_valid=1. Latency is WIDTH clock edges from the accept edge to res_valid high.
REQ-019 While in DONE, res_bcd and res_id SHALL hold stable until the edge on which res_valid and res_ready are both high; on that edge the FSM returns to IDLE and res_valid drops.
REQ-020 No new request SHALL be accepted on the same edge that a result is consumed; the earliest next accept is the following edge.
REQ-021 A requester SHALL keep priority while it is not served: the pointer changes only on an accept.
REQ-022 res_ready asserted outside DONE SHALL have no effect.
REQ-023 reqN_bin SHALL be sampled only on the accept edge; later changes do not affect the conversion in progress.
REQ-024 busy SHALL be high in CONV and DONE, and low in IDLE.

Reset
REQ-025 On a clk edge with rst_i=1, the block SHALL set:
- state to IDLE;
- res_valid=0, res_bcd=16'h0000, res_id=0;
- pointer=0 (requester 0 has priority);
- counter=0, shift register=0.
REQ-026 Reset asserted during CONV or DONE SHALL abandon the operation; no result is ever presented for it.
REQ-027 While rst_i=1, both reqN_ready outputs SHALL be 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the constant BCD_DIGITS=4, and the constant WIDTH_MAX=13.
REQ-029 The per-cycle add-3/shift step SHALL be a combinational sub-module module_dd_step: input {bcd[15:0], bin[WIDTH-1:0]}, output the shifted register.
REQ-030 The FSM, the arbiter pointer and the result registers SHALL reside in the top module.

Verification
REQ-031 Scenario: WIDTH=8, req0_valid=1, req0_bin=8'd255, res_ready=1 -> req0_ready pulses 1 cycle; 8 edges later res_valid=1, res_bcd=16'h0255, res_id=0.
REQ-032 Scenario: right after reset, both valid (req0_bin=8'd7, req1_bin=8'd42) -> req0 is served first (16'h0007, id 0); req1 is accepted on the edge after consumption and yields 16'h0042, id 1.
REQ-033 Scenario: res_ready held 0 for 20 cycles in DONE with 8'd99 -> res_bcd stays 16'h0099, busy=1, both reqN_ready=0; result consumed on the first edge res_ready=1.
REQ-034 Scenario: rst_i=1 pulse on the 3rd CONV cycle -> the next cycle is IDLE, res_valid=0, res_bcd=16'h0000, no result appears, and the pointer is back to requester 0.
REQ-035 Scenario: boundaries -> WIDTH=8, bin=0 gives 16'h0000; WIDTH=13, bin=13'd8191 gives 16'h8191 after 13 edges.
REQ-036 Scenario: req1 alone valid while the pointer is 0 -> req1 is granted immediately and the pointer becomes 0.

Source files
------------

// File: rtl/module_bcd_conv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// module_bcd_conv_arbiter_pkg
// Shared definitions for the two-requester binary-to-BCD converter:
//   - state_t      : FSM state encoding (IDLE, CONV, DONE)
//   - BCD_DIGITS   : number of BCD digits in the result (4)
//   - BCD_BITS     : result width in bits (16)
//   - WIDTH_MAX    : largest supported operand width (8191 fits in 4 digits)
//   - CNT_W        : iteration counter width, large enough to hold WIDTH_MAX
//   - add3_nibble  : the double-dabble digit correction
// -----------------------------------------------------------------------------
package module_bcd_conv_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_BITS   = BCD_DIGITS * 4;
    localparam int WIDTH_MAX  = 13;
    localparam int CNT_W      = $clog2(WIDTH_MAX + 1);

    // A digit of 5 or more would become >= 10 after the shift, so it is
    // pre-corrected by 3 so that the carry lands in the next digit.
    function automatic logic [3:0] add3_nibble(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/module_bcd_conv_arbiter_dd_step.sv
// -----------------------------------------------------------------------------
// module_dd_step
// One combinational double-dabble iteration over the register {bcd, bin}.
// Every BCD nibble >= 5 gets +3, then the whole register shifts left by one.
// Ports:
//   value   : in,  BCD_BITS+WIDTH bits, current {bcd[15:0], bin[WIDTH-1:0]}
//   shifted : out, BCD_BITS+WIDTH bits, register after correction and shift
// -----------------------------------------------------------------------------
module module_dd_step
    import module_bcd_conv_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [BCD_BITS+WIDTH-1:0] value,
    output logic [BCD_BITS+WIDTH-1:0] shifted
);

    logic [BCD_BITS+WIDTH-1:0] adjusted;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a full
        // default first, so no path can leave it unassigned and infer a latch.
        adjusted = value;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            adjusted[WIDTH + 4*d +: 4] = add3_nibble(value[WIDTH + 4*d +: 4]);
        end
    end

    // The BCD MSB falls off the top; it is always 0 for legal WIDTH.
    assign shifted = adjusted << 1;

endmodule

// File: rtl/module_bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// module_bcd_conv_arbiter
// Two requesters share one iterative binary-to-BCD converter. A round-robin
// pointer decides between simultaneous requests; the operand is converted one
// bit per cycle and the result is held until the consumer takes it.
// Ports:
//   clk, rst_i              : clock, synchronous active-high reset
//   req0_valid/bin/ready    : requester 0 handshake and operand
//   req1_valid/bin/ready    : requester 1 handshake and operand
//   res_valid/bcd/id/ready  : result handshake, 4-digit BCD, owning requester
//   busy                    : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module module_bcd_conv_arbiter
    import module_bcd_conv_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                req0_valid,
    input  logic [WIDTH-1:0]    req0_bin,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [WIDTH-1:0]    req1_bin,
    output logic                req1_ready,
    output logic                res_valid,
    output logic [BCD_BITS-1:0] res_bcd,
    output logic                res_id,
    input  logic                res_ready,
    output logic                busy
);

    localparam int SR_W = BCD_BITS + WIDTH;

    state_t              state;
    state_t              state_next;
    logic                ptr;
    logic [CNT_W-1:0]    cnt;
    logic [SR_W-1:0]     sreg;
    logic [SR_W-1:0]     sreg_step;
    logic [BCD_BITS-1:0] res_bcd_q;
    logic                res_id_q;
    logic                grant_any;
    logic                grant_id;
    logic                last_step;

    module_dd_step #(.WIDTH(WIDTH)) u_dd_step (
        .value   (sreg),
        .shifted (sreg_step)
    );

    assign last_step = (cnt == CNT_W'(1));

    // Arbiter: only IDLE grants, and reset masks the grant so no ready
    // leaks out while rst_i is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = ptr;
        if (state == ST_IDLE && !rst_i) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // Next state and FSM-derived outputs.
    always_comb begin
        state_next = state;
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any &&  grant_id;
        res_valid  = (state == ST_DONE);
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: if (grant_any) state_next = ST_CONV;
            ST_CONV: if (last_step) state_next = ST_DONE;
            // Consumption returns to IDLE; ready is low in DONE, so nothing
            // can be accepted on the consuming edge.
            ST_DONE: if (res_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            ptr       <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            res_bcd_q <= '0;
            res_id_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        sreg     <= {{BCD_BITS{1'b0}}, (grant_id ? req1_bin : req0_bin)};
                        cnt      <= CNT_W'(WIDTH);
                        res_id_q <= grant_id;
                        ptr      <= ~grant_id;
                    end
                end
                ST_CONV: begin
                    sreg <= sreg_step;
                    cnt  <= cnt - CNT_W'(1);
                    // Capture the finished digits so they stay put in DONE.
                    if (last_step) begin
                        res_bcd_q <= sreg_step[SR_W-1 -: BCD_BITS];
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_bcd = res_bcd_q;
    assign res_id  = res_id_q;

endmodule
